// File: rtl/nems_cfg_pkg.sv
// Shared types and constants for the NEMS relay configuration sequencer:
// FSM states, error-bit positions and default phase timing.
package nems_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_WAIT_WORD,
    ST_SETUP,
    ST_PULSE,
    ST_RELEASE,
    ST_DONE
  } state_e;

  localparam int unsigned ERR_SHORT = 0;
  localparam int unsigned ERR_LONG  = 1;
  localparam int unsigned ERR_ABORT = 2;

  localparam int unsigned DEF_ROWS       = 30;
  localparam int unsigned DEF_COLS       = 29;
  localparam int unsigned DEF_SETTLE_CYC = 8;
  localparam int unsigned DEF_PULSE_CYC  = 16;
  localparam int unsigned DEF_ERASE_CYC  = 64;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nems_phase_timer.sv
// Shared down-counter for the timed phases: load N-1 on phase entry and the
// phase lasts exactly N cycles, ending in the cycle where expired_o is high.
module nems_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/nems_relay_cfg_ctrl.sv
// Programs the tile's NEMS relay array column by column from a row-pattern
// stream, with optional global erase first and a latched hold at the end.
module nems_relay_cfg_ctrl
  import nems_cfg_pkg::*;
#(
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter int unsigned ERASE_CYC  = DEF_ERASE_CYC
) (
  input  logic            cfg_clk,
  input  logic            cfg_rst_n,
  input  logic            start,
  input  logic            erase_en,
  input  logic            abort,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [ROWS-1:0] wr_data,
  input  logic            wr_last,
  output logic [ROWS-1:0] cfgrows,
  output logic [COLS-1:0] cfgcols,
  output logic            cfg_erase,
  output logic            cfg_hold,
  output logic            busy,
  output logic            done,
  output logic [2:0]      err
);

  localparam int unsigned MAX_CYC = max3(ERASE_CYC, PULSE_CYC, SETTLE_CYC);
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1;

  state_e          state_q, state_d;
  logic [ROWS-1:0] word_q, word_d;
  logic            last_q, last_d;
  logic [CW-1:0]   col_q, col_d;
  logic [2:0]      err_q, err_d;

  logic [ROWS-1:0] rows_q, rows_d;
  logic [COLS-1:0] cols_q, cols_d;
  logic            erase_q, erase_d;
  logic            hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tmr_load;
  logic [TW-1:0]   tmr_value;
  logic            tmr_expired;

  nems_phase_timer #(.W(TW)) u_timer (
    .clk       (cfg_clk),
    .rst_n     (cfg_rst_n),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    last_d    = last_q;
    col_d     = col_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d = '0;
          col_d = '0;
          if (erase_en) begin
            state_d   = ST_ERASE;
            tmr_load  = 1'b1;
            tmr_value = TW'(ERASE_CYC - 1);
          end else begin
            state_d = ST_WAIT_WORD;
          end
        end
      end
      ST_ERASE: begin
        if (tmr_expired) state_d = ST_WAIT_WORD;
      end
      ST_WAIT_WORD: begin
        if (wr_valid) begin
          word_d    = wr_data;
          last_d    = wr_last;
          state_d   = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_value = TW'(SETTLE_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          state_d   = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_value = TW'(PULSE_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_expired) begin
          state_d   = ST_RELEASE;
          tmr_load  = 1'b1;
          tmr_value = TW'(SETTLE_CYC - 1);
        end
      end
      ST_RELEASE: begin
        if (tmr_expired) begin
          if (col_q == CW'(COLS - 1)) begin
            state_d = ST_DONE;
            if (!last_q) err_d[ERR_LONG] = 1'b1;
          end else if (last_q) begin
            state_d = ST_DONE;
            err_d[ERR_SHORT] = 1'b1;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = ST_WAIT_WORD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort only matters mid-sequence; in IDLE/DONE a coincident start wins.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_d          = ST_IDLE;
      tmr_load         = 1'b0;
      err_d[ERR_ABORT] = 1'b1;
    end
  end

  // Outputs are decoded from the next state so the tile sees registered lines.
  always_comb begin
    rows_d  = '0;
    cols_d  = '0;
    erase_d = 1'b0;
    hold_d  = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_d)
      ST_IDLE:  busy_d = 1'b0;
      ST_ERASE: begin
        erase_d = 1'b1;
        cols_d  = '1;
      end
      ST_WAIT_WORD: ;
      ST_SETUP, ST_RELEASE: rows_d = word_d;
      ST_PULSE: begin
        rows_d = word_d;
        cols_d = COLS'(1) << col_d;
      end
      ST_DONE: begin
        hold_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      col_q   <= '0;
      err_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      erase_q <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      col_q   <= col_d;
      err_q   <= err_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      erase_q <= erase_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_ready  = (state_q == ST_WAIT_WORD);
  assign cfgrows   = rows_q;
  assign cfgcols   = cols_q;
  assign cfg_erase = erase_q;
  assign cfg_hold  = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nems_relay_cfg_ctrl.sv
// Randomized bench for nems_relay_cfg_ctrl: each program run is planned as a
// per-cycle output timeline from the published phase timing, then replayed.
module tb_nems_relay_cfg_ctrl;

  localparam int ROWS = 30;
  localparam int COLS = 29;
  localparam int S    = 2;
  localparam int P    = 4;
  localparam int E    = 8;
  localparam int MAXC = 1024;

  logic            cfg_clk = 1'b0;
  logic            cfg_rst_n;
  logic            start, erase_en, abort, wr_valid, wr_last;
  logic [ROWS-1:0] wr_data;
  logic            wr_ready;
  logic [ROWS-1:0] cfgrows;
  logic [COLS-1:0] cfgcols;
  logic            cfg_erase, cfg_hold, busy, done;
  logic [2:0]      err;

  nems_relay_cfg_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(S), .PULSE_CYC(P), .ERASE_CYC(E)
  ) dut (
    .cfg_clk   (cfg_clk),
    .cfg_rst_n (cfg_rst_n),
    .start     (start),
    .erase_en  (erase_en),
    .abort     (abort),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .cfgrows   (cfgrows),
    .cfgcols   (cfgcols),
    .cfg_erase (cfg_erase),
    .cfg_hold  (cfg_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 cfg_clk = ~cfg_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Planned per-cycle expectations and stimulus; cycle 0 is the start cycle.
  logic [ROWS-1:0] exp_rows [MAXC];
  logic [COLS-1:0] exp_cols [MAXC];
  bit              exp_erase[MAXC], exp_hold[MAXC], exp_busy[MAXC];
  bit              exp_done [MAXC], exp_ready[MAXC];
  logic [2:0]      exp_err  [MAXC];
  bit              drv_valid[MAXC], drv_last[MAXC], drv_start[MAXC], drv_abort[MAXC];
  logic [ROWS-1:0] drv_data [MAXC];

  bit         prev_done = 1'b0;
  logic [2:0] prev_err  = 3'b000;

  task automatic run_program(input bit erase, input bit patt, input int last_idx,
                             input int gap_min, input int gap_max,
                             input int abort_col, input int stop_col);
    int p, t, gap, pre, k, len, a;
    bit fin;
    logic [2:0] fin_err;
    logic [ROWS-1:0] w;
    logic [ROWS-1:0] one_r;
    logic [COLS-1:0] one_c;
    int pstart[COLS];
    one_r = 1;
    one_c = 1;
    a = -1;
    for (int c = 0; c < MAXC; c++) begin
      exp_rows[c] = '0; exp_cols[c] = '0; exp_erase[c] = 0; exp_hold[c] = 0;
      exp_busy[c] = 0; exp_done[c] = 0; exp_ready[c] = 0; exp_err[c] = 3'b000;
      drv_valid[c] = 0; drv_last[c] = 1'($urandom); drv_data[c] = ROWS'($urandom);
      drv_start[c] = 0; drv_abort[c] = 0;
    end
    exp_done[0] = prev_done;
    exp_hold[0] = prev_done;
    exp_err[0]  = prev_err;
    p = 1;
    if (erase) begin
      for (int c = 1; c <= E; c++) begin
        exp_erase[c] = 1; exp_cols[c] = '1; exp_busy[c] = 1;
      end
      p = 1 + E;
    end
    fin = 0;
    fin_err = 3'b000;
    k = 0;
    while (!fin) begin
      gap = int'($urandom_range(gap_max, gap_min));
      pre = (gap == 0) ? int'($urandom_range(2, 0)) : 0;
      t = p + gap;
      if (pre > t) pre = t;
      w = patt ? (one_r << (k % ROWS)) : ROWS'($urandom);
      for (int c = p; c <= t; c++) begin
        exp_ready[c] = 1; exp_busy[c] = 1;
      end
      for (int c = t - pre; c <= t; c++) begin
        drv_valid[c] = 1; drv_data[c] = w; drv_last[c] = (k == last_idx);
      end
      for (int c = t + 1; c <= t + 2 * S + P; c++) begin
        exp_rows[c] = w; exp_busy[c] = 1;
      end
      pstart[k] = t + 1 + S;
      for (int c = pstart[k]; c < pstart[k] + P; c++) exp_cols[c] = one_c << k;
      p = t + 1 + 2 * S + P;
      if (k == COLS - 1) begin
        fin = 1;
        if (last_idx != k) fin_err = 3'b010;
      end else if (k == last_idx) begin
        fin = 1;
        fin_err = 3'b001;
      end
      k++;
    end
    len = p + 8;
    for (int c = p; c < len; c++) begin
      exp_done[c] = 1; exp_hold[c] = 1; exp_err[c] = fin_err;
      drv_valid[c] = 1;
    end
    if (abort_col >= 0) begin
      a = pstart[abort_col] + 1;
      len = a + 8;
      for (int c = a + 1; c < len; c++) begin
        exp_rows[c] = '0; exp_cols[c] = '0; exp_erase[c] = 0; exp_hold[c] = 0;
        exp_busy[c] = 0; exp_done[c] = 0; exp_ready[c] = 0; exp_err[c] = 3'b100;
      end
    end
    if (stop_col >= 0) len = pstart[stop_col] + 2;
    drv_abort[0] = 1'($urandom);
    for (int c = 1; c < len; c++) begin
      drv_start[c] = exp_busy[c] && ($urandom_range(15, 0) == 0);
      drv_abort[c] = (c == a) || (!exp_busy[c] && ($urandom_range(3, 0) == 0));
    end

    for (int c = 0; c < len; c++) begin
      start    = (c == 0) || drv_start[c];
      erase_en = (c == 0) ? erase : 1'($urandom);
      abort    = drv_abort[c];
      wr_valid = drv_valid[c];
      wr_data  = drv_data[c];
      wr_last  = drv_last[c];
      @(negedge cfg_clk);
      check($sformatf("c%0d rows", c),  64'(cfgrows),   64'(exp_rows[c]));
      check($sformatf("c%0d cols", c),  64'(cfgcols),   64'(exp_cols[c]));
      check($sformatf("c%0d erase", c), 64'(cfg_erase), 64'(exp_erase[c]));
      check($sformatf("c%0d hold", c),  64'(cfg_hold),  64'(exp_hold[c]));
      check($sformatf("c%0d busy", c),  64'(busy),      64'(exp_busy[c]));
      check($sformatf("c%0d done", c),  64'(done),      64'(exp_done[c]));
      check($sformatf("c%0d ready", c), 64'(wr_ready),  64'(exp_ready[c]));
      check($sformatf("c%0d err", c),   64'(err),       64'(exp_err[c]));
      @(posedge cfg_clk);
      #1;
    end
    prev_done = exp_done[len-1];
    prev_err  = exp_err[len-1];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rows"},  64'(cfgrows),   64'(0));
    check({tag, " cols"},  64'(cfgcols),   64'(0));
    check({tag, " erase"}, 64'(cfg_erase), 64'(0));
    check({tag, " hold"},  64'(cfg_hold),  64'(0));
    check({tag, " busy"},  64'(busy),      64'(0));
    check({tag, " done"},  64'(done),      64'(0));
    check({tag, " ready"}, 64'(wr_ready),  64'(0));
    check({tag, " err"},   64'(err),       64'(0));
  endtask

  initial begin
    int li;
    cfg_rst_n = 1'b0;
    start = 0; erase_en = 0; abort = 0; wr_valid = 0; wr_last = 0; wr_data = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge cfg_clk);
    #1 cfg_rst_n = 1'b1;
    @(posedge cfg_clk);
    #1;

    // Erase then full walking-one program, no stalls.
    run_program(1, 1, COLS - 1, 0, 0, -1, -1);
    // Short stream: last on word 5.
    run_program(0, 0, 5, 0, 2, -1, -1);
    // Long stream: no last; an extra word is then offered in DONE.
    run_program(0, 0, -1, 0, 1, -1, -1);
    // Ten-cycle stall between every word.
    run_program(0, 0, COLS - 1, 10, 10, -1, -1);
    // Abort in the pulse of column 3, then a fresh start clears err.
    run_program(1, 0, COLS - 1, 0, 2, 3, -1);
    run_program(0, 1, COLS - 1, 0, 3, -1, -1);
    for (int r = 0; r < 3; r++) begin
      li = int'($urandom_range(COLS, 0));
      if (li == COLS) li = -1;
      run_program(1'($urandom), 0, li, 0, 3, -1, -1);
    end

    // Asynchronous reset in the middle of column 1's pulse.
    run_program(0, 0, COLS - 1, 0, 1, -1, 1);
    #2 cfg_rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    wr_valid = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge cfg_clk);
    #3 cfg_rst_n = 1'b1;
    @(negedge cfg_clk);
    check_all_zero("post_rst");
    @(posedge cfg_clk);
    #1;
    prev_done = 1'b0;
    prev_err  = 3'b000;
    run_program(0, 0, 2, 0, 2, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nems_relay_cfg_ctrl.md
# nems_relay_cfg_ctrl

Sequencer that programs the NEMS relay routing array of a CLB tile through its shared row/column configuration lines (`cfgrows`/`cfgcols`). It accepts one row-pattern word per column over a valid/ready stream. It optionally erases the whole array first, then drives each column with coincident row/column actuation pulses and paced setup, pulse and release phases. After the last column it holds the array in the latched state. It sits between the chip-level configuration loader and the tile's `cfgrows`/`cfgcols` inputs; the CLB SRAM scan chain is not touched.

## Interface
- `ROWS`, 30, relay row lines driven per column
- `COLS`, 29, relay column lines; words per full program
- `SETTLE_CYC`, 8, setup and release phase length in cycles (≥1)
- `PULSE_CYC`, 16, column actuation pulse length in cycles (≥1)
- `ERASE_CYC`, 64, global erase phase length in cycles (≥1)

Ports:
- `cfg_clk` in 1: configuration clock; the only clock.
- `cfg_rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a program sequence; sampled in IDLE and DONE only.
- `erase_en` in 1: sampled with `start`; 1 inserts the ERASE phase.
- `abort` in 1: synchronous abort.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in ROWS, `wr_last` in 1: row-pattern stream.
- `cfgrows` out ROWS, `cfgcols` out COLS: to tile.
- `cfg_erase` out 1: erase bias enable.
- `cfg_hold` out 1: hold bias enable.
- `busy` out 1, `done` out 1.
- `err` out 3: {abort, long, short}, sticky until next accepted `start`.

## Operation
- Reset: all outputs 0, state IDLE, column index 0, `err`=0.
- States: IDLE, ERASE, WAIT_WORD, SETUP, PULSE, RELEASE, DONE.
- IDLE/DONE + `start`: clear `err`, column index := 0, `cfg_hold`:=0, `done`:=0. Go to ERASE if `erase_en`, else WAIT_WORD.
- ERASE: `cfg_erase`=1, `cfgcols`=all ones, `cfgrows`=0 for ERASE_CYC cycles, then WAIT_WORD.
- WAIT_WORD: `wr_ready`=1 (only state where it is 1); rows and cols are 0. A handshake latches `wr_data` and `wr_last`, then goes to SETUP.
- SETUP: `cfgrows`=latched word, `cfgcols`=0, for SETTLE_CYC cycles.
- PULSE: `cfgrows`=word, `cfgcols`=one-hot(column index), for PULSE_CYC cycles.
- RELEASE: `cfgcols`=0, `cfgrows`=word, for SETTLE_CYC cycles. On exit:
  - column index = COLS-1: go to DONE; if latched `wr_last`=0, set `err[1]` (long).
  - latched `wr_last`=1 with index < COLS-1: set `err[0]` (short), go to DONE; remaining columns are left unprogrammed.
  - otherwise: index+1, go to WAIT_WORD.
- DONE: `cfg_hold`=1, `done`=1, rows/cols 0. Extra stream words are never accepted (`wr_ready`=0).
- `busy`=1 in every state except IDLE and DONE.
- `abort` while busy: next cycle state=IDLE; rows, cols, `cfg_erase`, `cfg_hold` := 0; set `err[2]`. Abort in IDLE/DONE is ignored.
- `start` while busy is ignored. `abort` and `start` in the same cycle in DONE: `start` wins.
- Async reset mid-sequence forces all outputs to 0 immediately. No column may remain asserted.

## Timing
- All outputs are registered; no combinational input→output paths except `wr_ready`, which is a state decode.
- `start` accepted in cycle s:
  - with erase: `cfg_erase`=1 in cycles s+1..s+ERASE_CYC; `wr_ready`=1 from s+1+ERASE_CYC.
  - without erase: `wr_ready`=1 from s+1.
- Word accepted in cycle t:
  - `cfgrows` valid at t+1.
  - Column one-hot during t+1+SETTLE_CYC .. t+SETTLE_CYC+PULSE_CYC.
  - `wr_ready` next high at t+1+2·SETTLE_CYC+PULSE_CYC.
- Column high time is exactly PULSE_CYC. Rows are stable SETTLE_CYC before and after every column edge.
- Full program without erase and with zero stream stall takes COLS·(1+2·SETTLE_CYC+PULSE_CYC) cycles from the first `wr_ready`.

## Structure
- Package `nems_cfg_pkg`: state enum, `err` bit index constants, default timing constants.
- Sub-module `nems_phase_timer`:
  - down-counter sized to max(ERASE_CYC, PULSE_CYC, SETTLE_CYC);
  - `load`/`value` inputs, `expired` output;
  - shared by all timed phases.
- Column index counter is $clog2(COLS) bits; one-hot decode happens in the top.

## Test plan
Bench uses SETTLE_CYC=2, PULSE_CYC=4, ERASE_CYC=8.
- Erase+program: `start` with `erase_en`=1, 29 words 0x0000_0001<<(i%30), last on word 28. Required: `cfg_erase` high 8 cycles; each column one-hot 4 cycles with rows stable ±2 cycles; `done`=1, `cfg_hold`=1, `err`=0.
- Short stream: `wr_last` on word 5. Required: columns 0..5 pulsed only, `err`=3'b001, `done`=1.
- Long stream: no `wr_last` on word 28. Required: `err`=3'b010; word 29 held with `wr_valid`=1 is never accepted.
- Stall: `wr_valid` low 10 cycles between words. Required: rows and cols 0 during the gap; pulse widths unchanged.
- Abort during PULSE of column 3: `cfgcols`=0 next cycle, state IDLE, `err`=3'b100. A new `start` clears `err`.
- Async reset during PULSE: `cfgcols`/`cfgrows` 0 with no clock edge; `wr_ready`=0 after release from reset.
